// File: rtl/vga_timing_if.sv
// Pixel-timing bundle carried from the timing generator to the draw stages.
// The generator drives it through the master modport and consumers read it through the slave modport.
interface vga_timing_if;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        output hcount_out, vcount_out, hsync_out, hblnk_out,
               vsync_out, vblnk_out, frame_start, frame_cnt
    );

    modport slave (
        input  hcount_out, vcount_out, hsync_out, hblnk_out,
               vsync_out, vblnk_out, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync and blank decode,
// plus a start-of-frame pulse and a completed-frame counter.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         en,
    vga_timing_if.master vga
);

    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    function automatic logic in_range(input logic [10:0] v, input logic [10:0] lo,
                                      input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic sync_level(input logic active);
        return active ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic [10:0] hcount_r;
    logic [10:0] vcount_r;
    logic        hsync_r;
    logic        hblnk_r;
    logic        vsync_r;
    logic        vblnk_r;
    logic        frame_start_r;
    logic [15:0] frame_cnt_r;

    logic [10:0] hcount_nx_s;
    logic [10:0] vcount_nx_s;
    logic        wrap_s;

    // Next raster position; wrap_s marks the step from the last pixel of a frame back to (0,0).
    always_comb begin
        hcount_nx_s = hcount_r;
        vcount_nx_s = vcount_r;
        wrap_s      = 1'b0;
        if (hcount_r == H_LAST) begin
            hcount_nx_s = 11'd0;
            if (vcount_r == V_LAST) begin
                vcount_nx_s = 11'd0;
                wrap_s      = 1'b1;
            end else begin
                vcount_nx_s = vcount_r + 11'd1;
            end
        end else begin
            hcount_nx_s = hcount_r + 11'd1;
        end
    end

    // Counter and output registers; sync/blank decode the next position so they align with the counts.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            hcount_r      <= 11'd0;
            vcount_r      <= 11'd0;
            hsync_r       <= ~SYNC_POL;
            hblnk_r       <= 1'b0;
            vsync_r       <= ~SYNC_POL;
            vblnk_r       <= 1'b0;
            frame_start_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
        end else if (en) begin
            hcount_r      <= hcount_nx_s;
            vcount_r      <= vcount_nx_s;
            hsync_r       <= sync_level(in_range(hcount_nx_s, HS_FIRST, HS_LAST));
            hblnk_r       <= (hcount_nx_s >= H_ACT);
            vsync_r       <= sync_level(in_range(vcount_nx_s, VS_FIRST, VS_LAST));
            vblnk_r       <= (vcount_nx_s >= V_ACT);
            frame_start_r <= wrap_s;
            frame_cnt_r   <= wrap_s ? (frame_cnt_r + 16'd1) : frame_cnt_r;
        end else begin
            frame_start_r <= 1'b0;
        end
    end

    assign vga.hcount_out  = hcount_r;
    assign vga.vcount_out  = vcount_r;
    assign vga.hsync_out   = hsync_r;
    assign vga.hblnk_out   = hblnk_r;
    assign vga.vsync_out   = vsync_r;
    assign vga.vblnk_out   = vblnk_r;
    assign vga.frame_start = frame_start_r;
    assign vga.frame_cnt   = frame_cnt_r;

endmodule
